// File: rtl/vs_ser_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Holds the FSM state encoding and the bit-counter width function.
package vs_ser_pkg;

    typedef enum logic {
        VS_SER_IDLE  = 1'b0,
        VS_SER_SHIFT = 1'b1
    } vs_ser_state_t;

    // Bits needed to count down from width-1 to 0; never narrower than one bit.
    function automatic int vs_ser_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/vs_bit_counter.sv
// Down-counter tracking the remaining bits of the word being shifted out.
// Load has priority over decrement; is_zero marks the last bit of a word.
module vs_bit_counter
    import vs_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = vs_ser_cnt_w(WIDTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          is_zero
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - CW'(1);
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/vs_piso_serializer.sv
// Parallel-in serial-out shifter: word accepted on valid/ready, one bit per ser_en tick.
// First bit one cycle after accept; a new word can load on the last-bit tick, so frames have no gap.
module vs_piso_serializer
    import vs_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_first,
    output logic             done
);

    localparam int CW = vs_ser_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    vs_ser_state_t    state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             done_q;
    logic [CW-1:0]    count;
    logic             cnt_zero;
    logic             in_shift;
    logic             last_bit;
    logic             shift_bit;
    logic             accept;

    assign in_shift  = (state == VS_SER_SHIFT);
    assign last_bit  = in_shift && cnt_zero && ser_en;
    assign shift_bit = in_shift && ser_en && !cnt_zero;

    // Ready is also offered on the last-bit tick so back-to-back words leave no idle slot.
    assign in_ready = reset_n & ((state == VS_SER_IDLE) | last_bit);
    assign accept   = in_valid & in_ready;

    vs_bit_counter #(
        .WIDTH    (WIDTH)
    ) u_bit_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (CNT_MAX),
        .dec      (shift_bit),
        .count    (count),
        .is_zero  (cnt_zero)
    );

    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST) begin
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_next = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= VS_SER_IDLE;
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (accept) begin
                shreg <= in_data;
                state <= VS_SER_SHIFT;
            end else if (last_bit) begin
                shreg <= '0;
                state <= VS_SER_IDLE;
            end else if (shift_bit) begin
                shreg <= shreg_next;
            end
        end
    end

    assign ser_frame = in_shift;
    assign ser_out   = in_shift & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign ser_first = in_shift && (count == CNT_MAX);
    assign done      = done_q;

endmodule

// File: doc/vs_piso_serializer.md
Name: vs_piso_serializer

Overview:
Parallel-in, serial-out shift register. It is the transmit-side counterpart to the capture/storage flops and the serial-in, parallel-out deserializer. It accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per ser_en tick, with frame and first-bit markers. It supports back-to-back words with no idle bit slot. It sits between a word-oriented producer and any bit-serial link or bit-rate tick generator.

Parameters:
WIDTH, 8, word width in bits; must be at least 2.
MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
in_data  input  WIDTH  parallel word to transmit.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  serializer can accept a word this cycle.
ser_en  input  1  bit tick; the current ser_out bit is consumed on a clock edge where ser_en=1.
ser_out  output  1  current serial bit.
ser_frame  output  1  high while ser_out carries a valid word bit.
ser_first  output  1  high while ser_out carries the first bit of a word.
done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; shift register=0; bit counter=0.
  - ser_out=0, ser_frame=0, ser_first=0, done=0.
  - in_ready is forced to 0 while reset_n=0 (combinational AND with reset_n).
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, ser_frame=0, ser_out=0.
  - Accept occurs when in_valid and in_ready are both 1 at a clock edge: load in_data, set counter to WIDTH-1, go to SHIFT.
  - The first bit appears on ser_out in the cycle after the accept (latency 1).
- SHIFT:
  - ser_frame=1.
  - ser_out = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - ser_first=1 while counter equals WIDTH-1.
  - Edge with ser_en=1 and counter not 0: shift toward the output end, zero-fill, decrement counter.
  - Edge with ser_en=0: shreg, counter and outputs hold. An arbitrarily long stall is legal.
- Last bit (counter=0 and ser_en=1):
  - in_ready=1 combinationally in that cycle.
  - If in_valid=1: load the new word, counter=WIDTH-1, stay in SHIFT. ser_frame stays high with no gap, and ser_first rises next cycle.
  - If in_valid=0: go to IDLE.
  - In both cases done=1 in the following cycle, registered, for exactly one cycle.
- in_ready=0 in SHIFT except in the last-bit/ser_en cycle. A word held on in_valid is not consumed until in_ready=1. in_data must stay stable while in_valid=1 and in_ready=0.
- ser_en in IDLE is ignored.
- Reset mid-word: the word is discarded and outputs go to reset values immediately. There is no done pulse for the aborted word.
- Counter width is $clog2(WIDTH). Counter wrap-around never occurs, because the counter is reloaded or the block goes idle at 0.

Decomposition:
- Package vs_ser_pkg holds:
  - state typedef vs_ser_state_t {VS_SER_IDLE, VS_SER_SHIFT};
  - localparam function for counter width ($clog2 wrapper).
- One sub-module, vs_bit_counter (WIDTH parameter), providing:
  - load value, decrement-on-enable, is_zero flag;
  - asynchronous active-low reset.
- Shift register and FSM stay in vs_piso_serializer.

Test Plan:
- WIDTH=8, MSB_FIRST=1, ser_en=1 always, accept in_data=8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after the accept. ser_frame=1 for those 8 cycles, ser_first=1 on cycle 1 only, done=1 on cycle 9, then IDLE with in_ready=1.
- MSB_FIRST=0, in_data=8'h01, ser_en=1 -> ser_out 1,0,0,0,0,0,0,0. done pulses once.
- Back-to-back: in_valid held with 8'hF0 then 8'h0F -> 16 contiguous frame cycles with bits 11110000 00001111. ser_first=1 on cycles 1 and 9. in_ready=1 only at the accept and on cycle 8. done on cycles 9 and 17.
- Stall: ser_en toggling 1,0,0,1,... with 8'hC3 -> ser_out holds each bit through ser_en=0 cycles. The bit sequence is unchanged and done arrives after exactly 8 ser_en=1 edges.
- Reset mid-word: assert reset_n=0 after 3 bits of 8'hFF -> ser_out=0, ser_frame=0 and in_ready=0 immediately, with no done pulse. After release, in_ready=1 and the next word 8'h81 transmits correctly.
- Backpressure: in_valid=1 during SHIFT, before the last bit -> in_ready=0 and in_data is not sampled. The word is accepted exactly at the last-bit edge.
